mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_array.sv | 33 +++
 rtl/mem_responder.sv | 125 ++++++++++++
 tb/tb_mem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the wait-state memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        DRAIN
    } memStateT;

    localparam int DEFAULT_LATENCY = 2;
    localparam int DEFAULT_DEPTH   = 256;

    // Number of word-index bits taken from the byte address.
    function automatic int indexWidth(input int depthWords);
        return $clog2(depthWords);
    endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous word RAM with registered read
module mem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              writeEn,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] writeWord,
    output logic [DATA_W-1:0] readWord
);

    logic [DATA_W-1:0] words [DEPTH_WORDS];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (enable && writeEn) begin
            words[index] <= writeWord;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readWord <= '0;
        end else if (enable && !writeEn) begin
            readWord <= words[index];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder with one-shot request handshake
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = DEFAULT_DEPTH,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [DATA_W-1:0] MemData,
    output logic              MemReady,
    output logic              Busy,
    output logic              Fault
);

    localparam int IDX_W = indexWidth(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    memStateT          state, stateNext;
    logic [CNT_W-1:0]  count, countNext;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic              readQ, writeQ;
    logic              accept, access, badAccess;
    logic              ramEnable, ramWrite, dataZero;
    logic [DATA_W-1:0] ramData;

    // Checked against the latched request, never the live inputs.
    assign badAccess = (addrQ[1:0] != 2'b00)
                    || ((addrQ >> (IDX_W + 2)) != '0)
                    || (readQ && writeQ);

    // Gating with reset_n keeps a reset at the access edge from committing a write.
    assign ramEnable = access && reset_n && !badAccess;
    assign ramWrite  = ramEnable && writeQ;

    always_comb begin
        stateNext = state;
        countNext = count;
        accept    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    accept    = 1'b1;
                    countNext = CNT_LOAD;
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (count == '0) begin
                    access    = 1'b1;
                    stateNext = RESP;
                end else begin
                    countNext = count - CNT_W'(1);
                end
            end
            RESP:    stateNext = DRAIN;
            DRAIN: begin
                if (!MemRead && !MemWrite) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            addrQ    <= '0;
            wdataQ   <= '0;
            readQ    <= 1'b0;
            writeQ   <= 1'b0;
            MemReady <= 1'b0;
            Fault    <= 1'b0;
            dataZero <= 1'b1;
        end else begin
            state    <= stateNext;
            count    <= countNext;
            MemReady <= access;
            if (accept) begin
                addrQ  <= Address;
                wdataQ <= WriteData;
                readQ  <= MemRead;
                writeQ <= MemWrite;
            end
            // A good write leaves the previous read data visible.
            if (access) begin
                Fault <= badAccess;
                if (badAccess) begin
                    dataZero <= 1'b1;
                end else if (readQ) begin
                    dataZero <= 1'b0;
                end
            end
        end
    end

    assign MemData = dataZero ? '0 : ramData;
    assign Busy    = (state == WAIT) || (state == RESP);

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (ramEnable),
        .writeEn   (ramWrite),
        .index     (addrQ[IDX_W+1:2]),
        .writeWord (wdataQ),
        .readWord  (ramData)
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder at latency 2 and 5
module tb_mem_responder;

    typedef struct packed {
        logic [31:0] data;
        logic        fault;
    } respT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    int          which = 0;

    logic        rd2, wr2, rd5, wr5;
    logic [31:0] data2, data5;
    logic        ready2, ready5, busy2, busy5, fault2, fault5;
    logic [31:0] obsData;
    logic        obsReady, obsBusy, obsFault;

    int          checks = 0;
    int          failures = 0;
    respT        sb[$];
    logic [31:0] model [int];
    logic [31:0] lastData [2];

    always #5 clk = ~clk;

    assign rd2 = (which == 0) && MemRead;
    assign wr2 = (which == 0) && MemWrite;
    assign rd5 = (which == 1) && MemRead;
    assign wr5 = (which == 1) && MemWrite;

    assign obsData  = (which == 1) ? data5  : data2;
    assign obsReady = (which == 1) ? ready5 : ready2;
    assign obsBusy  = (which == 1) ? busy5  : busy2;
    assign obsFault = (which == 1) ? fault5 : fault2;

    mem_responder #(.LATENCY(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (rd2),
        .MemWrite  (wr2),
        .MemData   (data2),
        .MemReady  (ready2),
        .Busy      (busy2),
        .Fault     (fault2)
    );

    mem_responder #(.LATENCY(5)) dut5 (
        .clk       (clk),
        .reset_n   (reset_n),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (rd5),
        .MemWrite  (wr5),
        .MemData   (data5),
        .MemReady  (ready5),
        .Busy      (busy5),
        .Fault     (fault5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full request: accept, wait, respond, optionally keep holding, then release.
    task automatic transact(input logic [31:0] a, input logic [31:0] wd,
                            input logic rd, input logic wr, input int hold);
        respT e;
        int   key;
        int   lat;
        lat = (which == 1) ? 5 : 2;
        key = which * 1024 + int'(a[9:2]);
        e.fault = (a[1:0] != 2'b00) || (a[31:10] != '0) || (rd && wr);
        if (e.fault) begin
            e.data = '0;
        end else if (wr) begin
            model[key] = wd;
            e.data = lastData[which];
        end else begin
            e.data = model[key];
        end
        lastData[which] = e.data;
        sb.push_back(e);

        @(negedge clk);
        Address = a; WriteData = wd; MemRead = rd; MemWrite = wr;
        @(posedge clk); #1;
        check("busy_at_accept", 32'(obsBusy), 32'd1);
        WriteData = ~wd;
        for (int i = 1; i < lat; i++) begin
            @(posedge clk); #1;
            check("ready_early", 32'(obsReady), 32'd0);
            check("busy_wait", 32'(obsBusy), 32'd1);
        end
        @(posedge clk); #1;
        check("ready_on_time", 32'(obsReady), 32'd1);
        check("busy_resp", 32'(obsBusy), 32'd1);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("mem_data", obsData, e.data);
            check("fault", 32'(obsFault), 32'(e.fault));
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("ready_repeat", 32'(obsReady), 32'd0);
            check("busy_drain", 32'(obsBusy), 32'd0);
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge clk); #1;
        check("ready_one_cycle", 32'(obsReady), 32'd0);
        @(posedge clk); #1;
        check("busy_idle", 32'(obsBusy), 32'd0);
    endtask

    initial begin
        lastData[0] = '0;
        lastData[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data2, 32'd0);
        check("rst_ready", 32'(ready2), 32'd0);
        check("rst_busy", 32'(busy2), 32'd0);
        check("rst_fault", 32'(fault2), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        transact(32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 0);
        transact(32'h0000_0010, 32'h0,         1'b1, 1'b0, 0);
        transact(32'h0000_0000, 32'h1111_2222, 1'b0, 1'b1, 0);
        transact(32'h0000_03FC, 32'h0FFF_03FC, 1'b0, 1'b1, 0);
        transact(32'h0000_0000, 32'h0,         1'b1, 1'b0, 0);
        transact(32'h0000_03FC, 32'h0,         1'b1, 1'b0, 0);

        transact(32'h0000_0012, 32'h0,         1'b1, 1'b0, 0);
        transact(32'h0000_0400, 32'h0,         1'b1, 1'b0, 0);
        transact(32'h0000_0402, 32'h7777_7777, 1'b0, 1'b1, 0);
        transact(32'h0000_0000, 32'h0,         1'b1, 1'b0, 0);

        transact(32'h0000_0010, 32'h0BAD_0BAD, 1'b1, 1'b1, 0);
        transact(32'h0000_0010, 32'h0,         1'b1, 1'b0, 0);

        transact(32'h0000_0030, 32'hCAFE_F00D, 1'b0, 1'b1, 10);
        transact(32'h0000_0030, 32'h0,         1'b1, 1'b0, 0);

        // Reset lands while the write is still waiting: nothing may be committed.
        transact(32'h0000_0020, 32'hA5A5_0020, 1'b0, 1'b1, 0);
        transact(32'h0000_0020, 32'h0,         1'b1, 1'b0, 0);
        @(negedge clk);
        Address = 32'h0000_0020; WriteData = 32'h1234_5678; MemWrite = 1'b1;
        @(posedge clk); #1;
        check("busy_before_rst", 32'(busy2), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("abort_data", data2, 32'd0);
        check("abort_ready", 32'(ready2), 32'd0);
        check("abort_busy", 32'(busy2), 32'd0);
        check("abort_fault", 32'(fault2), 32'd0);
        MemWrite = 1'b0;
        lastData[0] = '0;
        lastData[1] = '0;
        @(negedge clk);
        reset_n = 1'b1;
        transact(32'h0000_0020, 32'h0,         1'b1, 1'b0, 0);

        which = 1;
        transact(32'h0000_0000, 32'h55AA_55AA, 1'b0, 1'b1, 0);
        transact(32'h0000_0000, 32'h0,         1'b1, 1'b0, 0);
        transact(32'h0000_0404, 32'h0,         1'b1, 1'b0, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
